// File: rtl/spi_flash_read_master.sv
// ---------------------------------------------------------------------------------------------
// spi_flash_read_master
//
// SPI mode-0 read initiator for an external (Q)SPI flash used in single-bit mode. A request
// issues READ (0x03), shifts out a 24-bit address MSB first, then clocks in `len` bytes. Each
// byte is presented on a valid/ready port.
//
// Parameters
//   CLK_DIV  system clocks per SCK half-period (1..255)
//   LEN_W    width of the byte-count input
//   CSB_GAP  minimum clocks flash_csb stays high after a transfer before busy drops (>= 1)
//
// Ports
//   clock, resetb        system clock (rising edge), asynchronous active-low reset
//   start, addr, len     one-cycle request; addr/len captured when accepted (idle, len != 0)
//   busy, done           transfer in progress / one-cycle pulse when flash_csb returns high
//   rd_data, rd_valid    received byte and its valid flag (held until rd_ready)
//   rd_ready             consumer accepts the byte when rd_valid && rd_ready
//   flash_csb, flash_clk chip select (active low), SCK (idles low)
//   flash_io0, flash_io1 MOSI out, MISO in
// ---------------------------------------------------------------------------------------------
module spi_flash_read_master #(
    parameter int unsigned CLK_DIV = 2,
    parameter int unsigned LEN_W   = 16,
    parameter int unsigned CSB_GAP = 4
) (
    input  logic             clock,
    input  logic             resetb,
    input  logic             start,
    input  logic [23:0]      addr,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    output logic [7:0]       rd_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic             flash_csb,
    output logic             flash_clk,
    output logic             flash_io0,
    input  logic             flash_io1
);

    localparam logic [7:0]       READ_CMD = 8'h03;
    localparam logic [7:0]       DIV_LAST = 8'(CLK_DIV - 1);
    localparam int unsigned      GAP_W    = (CSB_GAP > 1) ? $clog2(CSB_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CSB_GAP - 1);

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StAddr,
        StData,
        StStall,
        StGap
    } state_e;

    state_e           state_q, state_d;
    logic [7:0]       div_q, div_d;      // cycle count inside the current SCK half-period
    logic [4:0]       bit_q, bit_d;      // bit index in the header (0..31) or in a byte (0..7)
    logic [31:0]      tx_q, tx_d;        // header bits still to be driven, next one at [31]
    logic [7:0]       rx_q, rx_d;
    logic [LEN_W-1:0] left_q, left_d;    // bytes still to be delivered, including current
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             csb_q, csb_d;
    logic             sck_q, sck_d;
    logic             io0_q, io0_d;
    logic             done_q, done_d;
    logic [7:0]       rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;

    logic             phase_end;
    logic             load_byte;

    assign phase_end = (div_q == DIV_LAST);

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        bit_d      = bit_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        left_d     = left_q;
        gap_d      = gap_q;
        csb_d      = csb_q;
        sck_d      = sck_q;
        io0_d      = io0_q;
        done_d     = 1'b0;
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_valid_q;
        load_byte  = 1'b0;

        if (rd_valid_q && rd_ready) begin
            rd_valid_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (start && (len != '0)) begin
                    state_d = StCmd;
                    csb_d   = 1'b0;
                    sck_d   = 1'b0;
                    div_d   = '0;
                    bit_d   = '0;
                    io0_d   = READ_CMD[7];
                    tx_d    = {READ_CMD[6:0], addr, 1'b0};
                    left_d  = len;
                end
            end

            StCmd, StAddr, StData: begin
                if (!phase_end) begin
                    div_d = div_q + 8'd1;
                end else begin
                    div_d = '0;
                    if (!sck_q) begin
                        // Rising SCK: the flash has held MISO stable through the low phase.
                        sck_d = 1'b1;
                        rx_d  = {rx_q[6:0], flash_io1};
                    end else if (state_q != StData) begin
                        // End of a header bit: drop SCK and present the next MOSI bit.
                        sck_d = 1'b0;
                        io0_d = tx_q[31];
                        tx_d  = {tx_q[30:0], 1'b0};
                        bit_d = bit_q + 5'd1;
                        if (bit_q == 5'd7) begin
                            state_d = StAddr;
                        end
                        if (bit_q == 5'd31) begin
                            state_d = StData;
                            io0_d   = 1'b0;
                            bit_d   = '0;
                        end
                    end else begin
                        sck_d = 1'b0;
                        bit_d = bit_q + 5'd1;
                        if (bit_q == 5'd7) begin
                            // Full byte in rx_q; park with SCK low if the consumer is behind.
                            if (!rd_valid_q || rd_ready) begin
                                load_byte = 1'b1;
                            end else begin
                                state_d = StStall;
                            end
                        end
                    end
                end
            end

            StStall: begin
                if (rd_ready) begin
                    load_byte = 1'b1;
                end
            end

            StGap: begin
                if (gap_q != GAP_LAST) begin
                    gap_d = gap_q + GAP_W'(1);
                end else if (!rd_valid_q || rd_ready) begin
                    // Idle only once the final byte has left the output register.
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        if (load_byte) begin
            rd_data_d  = rx_q;
            rd_valid_d = 1'b1;
            sck_d      = 1'b0;
            div_d      = '0;
            bit_d      = '0;
            if (left_q == LEN_W'(1)) begin
                state_d = StGap;
                gap_d   = '0;
                csb_d   = 1'b1;
                io0_d   = 1'b0;
                done_d  = 1'b1;
            end else begin
                state_d = StData;
                left_d  = left_q - LEN_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state_q    <= StIdle;
            div_q      <= '0;
            bit_q      <= '0;
            tx_q       <= '0;
            rx_q       <= '0;
            left_q     <= '0;
            gap_q      <= '0;
            csb_q      <= 1'b1;
            sck_q      <= 1'b0;
            io0_q      <= 1'b0;
            done_q     <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            left_q     <= left_d;
            gap_q      <= gap_d;
            csb_q      <= csb_d;
            sck_q      <= sck_d;
            io0_q      <= io0_d;
            done_q     <= done_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign busy      = (state_q != StIdle);
    assign done      = done_q;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign flash_csb = csb_q;
    assign flash_clk = sck_q;
    assign flash_io0 = io0_q;

endmodule

// File: tb/tb_spi_flash_read_master.sv
// ---------------------------------------------------------------------------------------------
// tb_spi_flash_read_master
//
// Two instances share one behavioural flash: dut0 with CLK_DIV=2 and dut1 with CLK_DIV=1,
// selected by `sel`. The flash decodes command/address from MOSI on SCK rises and serves bytes
// from an image function on SCK falls. Transfers are scored against a queue of image bytes.
// ---------------------------------------------------------------------------------------------
module tb_spi_flash_read_master;

    localparam int CSB_GAP = 4;

    logic        clock;
    logic        resetb;
    logic        start;
    logic [23:0] addr;
    logic [15:0] len;
    logic        rd_ready;
    logic        sel;
    logic        miso;

    logic        d0_busy, d0_done, d0_valid, d0_csb, d0_clk, d0_io0;
    logic        d1_busy, d1_done, d1_valid, d1_csb, d1_clk, d1_io0;
    logic [7:0]  d0_data, d1_data;
    logic        start0, start1;

    logic        busy_m, done_m, rd_valid_m, csb_m, clk_m, io0_m;
    logic [7:0]  rd_data_m;

    int          n_cmp;
    int          n_bad;

    // Flash model state
    int          f_rise;
    logic [31:0] f_hdr;
    int          f_ones;
    int          f_idx;
    logic [7:0]  f_byte;

    assign start0 = start && !sel;
    assign start1 = start && sel;

    assign busy_m     = sel ? d1_busy  : d0_busy;
    assign done_m     = sel ? d1_done  : d0_done;
    assign rd_valid_m = sel ? d1_valid : d0_valid;
    assign rd_data_m  = sel ? d1_data  : d0_data;
    assign csb_m      = sel ? d1_csb   : d0_csb;
    assign clk_m      = sel ? d1_clk   : d0_clk;
    assign io0_m      = sel ? d1_io0   : d0_io0;

    spi_flash_read_master #(.CLK_DIV(2), .LEN_W(16), .CSB_GAP(CSB_GAP)) dut0 (
        .clock(clock), .resetb(resetb), .start(start0), .addr(addr), .len(len),
        .busy(d0_busy), .done(d0_done), .rd_data(d0_data), .rd_valid(d0_valid),
        .rd_ready(rd_ready), .flash_csb(d0_csb), .flash_clk(d0_clk), .flash_io0(d0_io0),
        .flash_io1(miso)
    );

    spi_flash_read_master #(.CLK_DIV(1), .LEN_W(16), .CSB_GAP(CSB_GAP)) dut1 (
        .clock(clock), .resetb(resetb), .start(start1), .addr(addr), .len(len),
        .busy(d1_busy), .done(d1_done), .rd_data(d1_data), .rd_valid(d1_valid),
        .rd_ready(rd_ready), .flash_csb(d1_csb), .flash_clk(d1_clk), .flash_io0(d1_io0),
        .flash_io1(miso)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [7:0] img(input logic [23:0] a);
        logic [7:0] t;
        case (a)
            24'h000000: t = 8'h93;
            24'h000001: t = 8'h00;
            24'h000002: t = 8'h00;
            24'h000003: t = 8'h0B;
            default: begin
                t = a[7:0] * 8'd29;
                t = t ^ a[15:8] ^ a[23:16] ^ 8'h5A;
            end
        endcase
        return t;
    endfunction

    // Flash: header captured on SCK rises; the count restarts when CSB falls (SCK is low then).
    always @(posedge clk_m or negedge csb_m) begin
        if (clk_m && !csb_m) begin
            if (f_rise < 32) f_hdr <= {f_hdr[30:0], io0_m};
            else if (io0_m) f_ones <= f_ones + 1;
            f_rise <= f_rise + 1;
        end else if (!csb_m) begin
            f_rise <= 0;
            f_hdr  <= '0;
            f_ones <= 0;
        end
    end

    // Flash: present the next data bit on each SCK fall once the header is complete.
    always @(negedge clk_m) begin
        if (!csb_m && f_rise >= 32) begin
            f_idx  = f_rise - 32;
            f_byte = img(f_hdr[23:0] + 24'(f_idx / 8));
            miso   = f_byte[7 - (f_idx % 8)];
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // mode: 0 ready always, 1 ready low for 40 cycles after first valid, 2 toggle, 3 random.
    // inj: nonzero -> pulse a conflicting start at cycles inj and inj+100 of the transfer.
    task automatic xfer(input logic [23:0] a, input int n, input int mode, input int inj);
        logic [7:0] exp_q[$];
        logic [7:0] want;
        int         div, cyc, budget, csb_low, rises, dones, got, hold_bad;
        int         done_cyc, v_clr, first_v, gap_need, unstalled;
        logic       prev_clk;

        div      = sel ? 1 : 2;
        budget   = 20000;
        csb_low  = 0;
        rises    = 0;
        dones    = 0;
        got      = 0;
        hold_bad = 0;
        done_cyc = -1;
        v_clr    = -1;
        first_v  = -1;
        prev_clk = 1'b0;
        for (int i = 0; i < n; i++) exp_q.push_back(img(a + 24'(i)));

        @(negedge clock);
        check("idle_csb", csb_m, 1'b1);
        start    = 1'b1;
        addr     = a;
        len      = 16'(n);
        rd_ready = (mode == 0);
        @(negedge clock);
        start = 1'b0;
        check("start_csb", csb_m, 1'b0);
        check("start_busy", busy_m, 1'b1);
        check("start_sck", clk_m, 1'b0);
        check("start_mosi", io0_m, 1'b0);

        cyc = 1;
        while (busy_m && cyc < budget) begin
            if (inj != 0 && (cyc == inj || cyc == inj + 100)) begin
                start = 1'b1;
                addr  = 24'hABCDEF;
                len   = 16'd7;
            end else begin
                start = 1'b0;
            end
            if (!csb_m) csb_low++;
            if (clk_m && !prev_clk) rises++;
            prev_clk = clk_m;
            if (done_m) begin
                dones++;
                done_cyc = cyc;
            end
            if (rd_valid_m && first_v < 0) first_v = cyc;
            if (mode == 1 && first_v >= 0 && cyc - first_v >= 32 && cyc - first_v < 40 &&
                (clk_m || csb_m)) hold_bad++;
            case (mode)
                0:       rd_ready = 1'b1;
                1:       rd_ready = (first_v >= 0 && cyc - first_v >= 40);
                2:       rd_ready = (cyc % 2 == 1);
                default: rd_ready = 1'($urandom_range(0, 1));
            endcase
            if (rd_valid_m && rd_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_byte", 1'b1, 1'b0);
                end else begin
                    want = exp_q.pop_front();
                    check("byte", rd_data_m, want);
                end
                got++;
            end
            if (done_cyc >= 0 && v_clr < 0 && !rd_valid_m) v_clr = cyc;
            @(negedge clock);
            cyc++;
        end
        start = 1'b0;
        if (v_clr < 0) v_clr = cyc;

        unstalled = (32 + 8 * n) * 2 * div;
        check("no_timeout", cyc < budget, 1'b1);
        check("byte_count", got, n);
        check("bytes_pending", exp_q.size(), 0);
        check("done_pulses", dones, 1);
        check("sck_rises", rises, 32 + 8 * n);
        check("header", f_hdr, {8'h03, a});
        check("mosi_data_zero", f_ones, 0);
        check("rd_valid_idle", rd_valid_m, 1'b0);
        if (mode == 0 || mode == 2) check("csb_low_len", csb_low, unstalled);
        if (mode == 1) begin
            check("csb_low_stalled", csb_low, unstalled + 9);
            check("stall_sck_low", hold_bad, 0);
        end
        if (mode == 3) check("csb_low_min", csb_low >= unstalled, 1'b1);
        gap_need = (v_clr - done_cyc > CSB_GAP) ? v_clr - done_cyc : CSB_GAP;
        check("busy_fall", cyc, done_cyc + gap_need);
    endtask

    initial begin
        int act;
        n_cmp    = 0;
        n_bad    = 0;
        resetb   = 1'b0;
        start    = 1'b0;
        addr     = '0;
        len      = '0;
        rd_ready = 1'b0;
        sel      = 1'b0;
        miso     = 1'b0;

        repeat (3) @(negedge clock);
        check("rst_busy", busy_m, 1'b0);
        check("rst_done", done_m, 1'b0);
        check("rst_valid", rd_valid_m, 1'b0);
        check("rst_data", rd_data_m, 8'h00);
        check("rst_csb", csb_m, 1'b1);
        check("rst_sck", clk_m, 1'b0);
        check("rst_mosi", io0_m, 1'b0);
        resetb = 1'b1;

        // Basic read of the image head, consumer always ready.
        xfer(24'h000000, 4, 0, 0);
        // Consumer backpressure forces a stall on the second byte.
        xfer(24'h000002, 3, 1, 0);

        // len = 0 start is ignored.
        @(negedge clock);
        start = 1'b1;
        addr  = 24'h123456;
        len   = 16'd0;
        @(negedge clock);
        start = 1'b0;
        act   = 0;
        repeat (20) begin
            if (!csb_m || busy_m || clk_m) act++;
            @(negedge clock);
        end
        check("len0_no_activity", act, 0);

        // Starts while busy must not disturb the captured request.
        xfer(24'h000001, 2, 0, 5);

        // Asynchronous reset during the address phase.
        @(negedge clock);
        start    = 1'b1;
        addr     = 24'h000000;
        len      = 16'd4;
        rd_ready = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (60) @(negedge clock);
        check("pre_reset_csb", csb_m, 1'b0);
        resetb = 1'b0;
        #1;
        check("async_rst_csb", csb_m, 1'b1);
        check("async_rst_sck", clk_m, 1'b0);
        check("async_rst_busy", busy_m, 1'b0);
        check("async_rst_valid", rd_valid_m, 1'b0);
        check("async_rst_done", done_m, 1'b0);
        repeat (3) @(negedge clock);
        resetb = 1'b1;
        @(negedge clock);
        check("post_rst_idle", busy_m, 1'b0);
        xfer(24'h000000, 4, 0, 0);

        // Fastest SCK with a toggling consumer.
        sel = 1'b1;
        xfer(24'h000000, 2, 2, 0);
        for (int r = 0; r < 2; r++) begin
            xfer(24'($urandom), int'($urandom_range(1, 5)), 3, 0);
        end

        sel = 1'b0;
        xfer(24'hFFFFFE, 4, 3, 0);
        for (int r = 0; r < 5; r++) begin
            xfer(24'($urandom), int'($urandom_range(1, 5)), 3, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
